// File: rtl/flit_reassembler.sv
// Reassembles FLITS-flit groups (MSB flit first) into packets and queues them in a DEPTH-entry FIFO.
// Optional partial-packet timeout with drop_err pulse is built when FLIT_REASM_TIMEOUT_EN is defined.
module flit_reassembler #(
    parameter int PKT_WIDTH  = 32,
    parameter int FLIT_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic [FLIT_WIDTH-1:0]                    flit_in,
    input  logic                                     flit_valid,
    output logic                                     flit_ready,
    output logic [PKT_WIDTH-1:0]                     pkt_out,
    output logic                                     pkt_valid,
    input  logic                                     pkt_ready,
    output logic                                     full,
    output logic                                     empty,
    output logic [$clog2(PKT_WIDTH/FLIT_WIDTH):0]    flit_cnt,
    output logic                                     drop_err
);
    localparam int FLITS = PKT_WIDTH / FLIT_WIDTH;
    localparam int CW    = $clog2(FLITS) + 1;
    localparam int AW    = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

    state_t                 state, state_next;
    logic [PKT_WIDTH-1:0]   shreg;
    logic [PKT_WIDTH-1:0]   assembled;
    logic [PKT_WIDTH-1:0]   push_data;
    logic [PKT_WIDTH-1:0]   mem [DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [AW:0]            count;
    logic                   accept, pop, space, last_flit, push, timeout_hit;

    assign accept    = flit_valid && flit_ready;
    assign pop       = pkt_valid && pkt_ready;
    assign space     = !full || pop;
    assign last_flit = (state == COLLECT) && accept && (flit_cnt == CW'(FLITS - 1));
    assign push      = (last_flit || (state == HOLD)) && space;
    assign assembled = {shreg[PKT_WIDTH-FLIT_WIDTH-1:0], flit_in};
    assign push_data = (state == HOLD) ? shreg : assembled;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: defaulting state_next before the case keeps this block free of inferred latches.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = COLLECT;
            COLLECT: begin
                if (timeout_hit)    state_next = IDLE;
                else if (last_flit) state_next = space ? IDLE : HOLD;
            end
            HOLD:    if (space) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        flit_ready = (state != HOLD);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shreg    <= '0;
            flit_cnt <= '0;
        end else if (timeout_hit) begin
            shreg    <= '0;
            flit_cnt <= '0;
        end else if (accept) begin
            // A final flit with no FIFO space parks the whole packet in shreg for HOLD.
            shreg <= assembled;
            if (last_flit) flit_cnt <= space ? '0 : CW'(FLITS);
            else           flit_cnt <= flit_cnt + 1'b1;
        end else if ((state == HOLD) && space) begin
            flit_cnt <= '0;
        end
    end

    // NOTE: storage is not reset; pointers and count define validity and pkt_out is gated by empty.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign full      = (count == (AW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign pkt_valid = !empty;
    assign pkt_out   = empty ? '0 : mem[rd_ptr];

`ifdef FLIT_REASM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] idle_cnt;
    logic          drop_q;

    // An accept in the expiry cycle wins, so an in-flight flit is never silently lost.
    assign timeout_hit = (state == COLLECT) && !accept && (idle_cnt == TW'(TIMEOUT));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idle_cnt <= '0;
            drop_q   <= 1'b0;
        end else begin
            drop_q <= timeout_hit;
            if (accept || timeout_hit || (state != COLLECT)) idle_cnt <= '0;
            else                                             idle_cnt <= idle_cnt + 1'b1;
        end
    end

    assign drop_err = drop_q;
`else
    assign timeout_hit = 1'b0;
    assign drop_err    = 1'b0;
`endif

endmodule
